// File: rtl/operand_deserializer_pkg.sv
// operand_deserializer_pkg: shared state encoding and default operand MSB index
package operand_deserializer_pkg;
    localparam int NBITS_DEFAULT = 7;
    typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/operand_deserializer_if.sv
// operand_deserializer_if: serial bit-pair input and parallel frame output handshake
interface operand_deserializer_if import operand_deserializer_pkg::*; #(
    parameter int Nbits = NBITS_DEFAULT
);
    logic s_a;
    logic s_b;
    logic s_valid;
    logic s_ready;
    logic s_abort;
    logic [Nbits:0] a;
    logic [Nbits:0] b;
    logic m_valid;
    logic m_ready;
    modport master (output s_a, s_b, s_valid, s_abort, m_ready, input s_ready, a, b, m_valid);
    modport slave (input s_a, s_b, s_valid, s_abort, m_ready, output s_ready, a, b, m_valid);
endinterface

// File: rtl/operand_deserializer_shift_reg.sv
// shift_reg_lsb: LSB-first shift register, new bit enters at the MSB
module shift_reg_lsb import operand_deserializer_pkg::*; #(
    parameter int Nbits = NBITS_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic           din,
    output logic [Nbits:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else q <= clr ? '0 : (en ? {din, q[Nbits:1]} : q);
endmodule

// File: rtl/operand_deserializer.sv
// operand_deserializer: collects Nbits+1 serial bit pairs into parallel operands a/b
module operand_deserializer import operand_deserializer_pkg::*; #(
    parameter int Nbits = NBITS_DEFAULT
) (
    input logic clk,
    input logic rst,
    operand_deserializer_if.slave bus
);
    localparam int CW = $clog2(Nbits + 2);
    state_t r_state;
    logic [CW-1:0] r_cnt;
    logic r_m_valid;
    logic r_s_ready;
    logic w_load;
    logic w_clr;
    logic w_accept;
    logic w_last;
    logic w_release;
    logic [Nbits:0] w_a;
    logic [Nbits:0] w_b;
    assign w_load    = (r_state == LOAD);
    assign w_clr     = w_load & bus.s_abort;
    assign w_accept  = w_load & bus.s_valid & ~bus.s_abort;
    assign w_last    = w_accept & (r_cnt == CW'(Nbits));
    assign w_release = ~w_load & bus.m_ready;
    // Handshake outputs are registered alongside the state so they never glitch
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
        end else begin
            r_state   <= w_last ? HOLD : (w_release ? LOAD : r_state);
            r_cnt     <= (w_clr | w_last) ? '0 : r_cnt + CW'(w_accept);
            r_m_valid <= w_last ? 1'b1 : (w_release ? 1'b0 : r_m_valid);
            r_s_ready <= w_last ? 1'b0 : (w_release ? 1'b1 : r_s_ready);
        end
    shift_reg_lsb #(.Nbits(Nbits)) u_sr_a (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_accept), .din(bus.s_a), .q(w_a)
    );
    shift_reg_lsb #(.Nbits(Nbits)) u_sr_b (
        .clk(clk), .rst(rst), .clr(w_clr), .en(w_accept), .din(bus.s_b), .q(w_b)
    );
    assign bus.a       = w_a;
    assign bus.b       = w_b;
    assign bus.m_valid = r_m_valid;
    assign bus.s_ready = r_s_ready;
endmodule
